// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake, radix-2 shift-add multiplier
// returning the full double-width product, and overflow/illegal-opcode flags.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       alu_cs,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             ZERO,
  output logic             OVF,
  output logic             ILLEGAL
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_MUL = 6'b011000;
  localparam logic [5:0] OP_SLT = 6'b101010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   prod_hi;
  logic [WIDTH-1:0]   prod_lo;

  logic signed [WIDTH-1:0] a_s, b_s, sum_s, diff_s;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_ovf, alu_ill;

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] addend, hi_nxt, lo_nxt;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  assign a_s    = A;
  assign b_s    = B;
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (alu_cs)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_ADD: begin
        alu_res = sum_s;
        alu_ovf = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_s;
        alu_ovf = sub_ovf(a_s[WIDTH-1], b_s[WIDTH-1], diff_s[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_MUL: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // {prod_hi, prod_lo} shifts right one bit per cycle; the multiplier drains out
  // of prod_lo while product bits fill in from the top. acc keeps the carry.
  assign addend = prod_lo[0] ? mcand : '0;
  assign acc    = {1'b0, prod_hi} + {1'b0, addend};
  assign hi_nxt = acc[WIDTH:1];
  assign lo_nxt = {acc[0], prod_lo[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mcand     <= '0;
      prod_hi   <= '0;
      prod_lo   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      ZERO      <= 1'b1;
      OVF       <= 1'b0;
      ILLEGAL   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (alu_cs == OP_MUL) begin
              mcand   <= A;
              prod_lo <= B;
              prod_hi <= '0;
              cnt     <= '0;
              state   <= S_MUL;
            end else begin
              result    <= alu_res;
              result_hi <= '0;
              ZERO      <= (alu_res == '0);
              OVF       <= alu_ovf;
              ILLEGAL   <= alu_ill;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          prod_hi <= hi_nxt;
          prod_lo <= lo_nxt;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result    <= lo_nxt;
            result_hi <= hi_nxt;
            ZERO      <= (lo_nxt == '0);
            OVF       <= 1'b0;
            ILLEGAL   <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq: a transaction-level reference model predicts
// busy/done timing and the held outputs, compared every cycle on the falling edge.
module tb_alu_seq;
  localparam int W = 32;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_MUL = 6'b011000;
  localparam logic [5:0] OP_SLT = 6'b101010;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [5:0]   alu_cs = '0;
  logic         busy, done, ZERO, OVF, ILLEGAL;
  logic [W-1:0] result, result_hi;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .alu_cs(alu_cs),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .ZERO(ZERO), .OVF(OVF), .ILLEGAL(ILLEGAL)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         ovf;
    logic         ill;
  } out_t;

  function automatic out_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [5:0] op);
    out_t r;
    longint sa, sb, s, smax, smin;
    logic [63:0] p;
    r = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    case (op)
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_ADD: begin s = sa + sb; r.res = W'(s); r.ovf = (s > smax) || (s < smin); end
      OP_SUB: begin s = sa - sb; r.res = W'(s); r.ovf = (s > smax) || (s < smin); end
      OP_SLT: r.res = (sa < sb) ? W'(1) : W'(0);
      OP_MUL: begin
        p = 64'(a) * 64'(b);
        r.res = p[W-1:0];
        r.hi  = p[2*W-1:W];
      end
      default: r.ill = 1'b1;
    endcase
    r.zero = (r.res == '0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: countdown to done, then one busy cycle with done high.
  out_t m_out, m_pend;
  logic m_busy, m_done;
  int   m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_out  <= '{res: '0, hi: '0, zero: 1'b1, ovf: 1'b0, ill: 1'b0};
      m_pend <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_out  <= m_pend;
        m_done <= 1'b1;
      end
    end else if (start && !m_busy) begin
      m_busy <= 1'b1;
      if (alu_cs == OP_MUL) begin
        m_pend <= ref_op(A, B, alu_cs);
        m_cnt  <= W;
      end else begin
        m_out  <= ref_op(A, B, alu_cs);
        m_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("result", 64'(result), 64'(m_out.res));
      chk("result_hi", 64'(result_hi), 64'(m_out.hi));
      chk("ZERO", 64'(ZERO), 64'(m_out.zero));
      chk("OVF", 64'(OVF), 64'(m_out.ovf));
      chk("ILLEGAL", 64'(ILLEGAL), 64'(m_out.ill));
    end
  end

  // Issue one op; returns cycles until done (or -1 on timeout). Optionally
  // injects a stray start pulse while busy and scrambles inputs after acceptance.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op,
                       input int stray_at, output int lat);
    @(negedge clk);
    A = a; B = b; alu_cs = op; start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = (c == stray_at);
      if (c == stray_at) alu_cs = OP_AND;
      else begin
        A = $urandom; B = $urandom; alu_cs = 6'($urandom);
      end
      if (done) begin
        lat = c;
        start = 1'b0;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 64'(0), 64'(1));
  endtask

  logic [5:0] ops[6] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_SLT};

  initial begin
    int lat;
    logic [5:0] op;
    out_t pin;

    pin = ref_op(32'd30, 32'd25, OP_MUL);
    chk("model_mul", 64'(pin.res), 64'd750);
    pin = ref_op(32'h7FFFFFFF, 32'd1, OP_ADD);
    chk("model_ovf", 64'(pin.ovf), 64'd1);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(ZERO), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);

    do_op(32'd30, 32'd25, OP_MUL, 0, lat);
    chk("mul_lat", 64'(lat), 64'(W + 1));
    chk("mul_res", 64'(result), 64'd750);
    chk("mul_hi", 64'(result_hi), 64'd0);
    chk("mul_zero", 64'(ZERO), 64'd0);

    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, OP_MUL, 0, lat);
    chk("mulff_lo", 64'(result), 64'h1);
    chk("mulff_hi", 64'(result_hi), 64'hFFFFFFFE);

    do_op(32'h7FFFFFFF, 32'd1, OP_ADD, 0, lat);
    chk("add_lat", 64'(lat), 64'd1);
    chk("add_res", 64'(result), 64'h80000000);
    chk("add_ovf", 64'(OVF), 64'd1);

    do_op(32'd25, 32'd25, OP_SUB, 0, lat);
    chk("sub_zero", 64'(ZERO), 64'd1);
    chk("sub_ovf", 64'(OVF), 64'd0);

    do_op(32'hFFFFFFFE, 32'd3, OP_SLT, 0, lat);
    chk("slt_res", 64'(result), 64'd1);

    do_op(32'd7, 32'd9, OP_MUL, 5, lat);
    chk("stray_lat", 64'(lat), 64'(W + 1));
    chk("stray_res", 64'(result), 64'd63);

    // Abort a multiply with reset partway through.
    @(negedge clk);
    A = 32'd123; B = 32'd456; alu_cs = OP_MUL; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_res", 64'(result), 64'd0);
    chk("abort_zero", 64'(ZERO), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    do_op(32'd3, 32'd4, OP_ADD, 0, lat);
    chk("post_rst_lat", 64'(lat), 64'd1);
    chk("post_rst_res", 64'(result), 64'd7);

    do_op(32'd1, 32'd2, 6'b111111, 0, lat);
    chk("ill_flag", 64'(ILLEGAL), 64'd1);
    chk("ill_res", 64'(result), 64'd0);
    chk("ill_zero", 64'(ZERO), 64'd1);
    do_op(32'hF0, 32'h0F, OP_OR, 0, lat);
    chk("or_res", 64'(result), 64'hFF);
    chk("or_ill", 64'(ILLEGAL), 64'd0);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 7))
        6: op = 6'($urandom);
        7: op = OP_MUL;
        default: op = ops[$urandom_range(0, 5)];
      endcase
      do_op($urandom, ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom, op,
            (op == OP_MUL && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, W)) : 0, lat);
      if ($urandom_range(0, 2) == 0) begin
        // start pulse during the DONE cycle must be dropped
        A = $urandom; B = $urandom; alu_cs = ops[$urandom_range(0, 5)]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the combinational ALU. It keeps the same opcode encoding on alu_cs and the same A/B/result/ZERO naming. It adds:
- a start/busy/done handshake,
- a multi-cycle shift-add multiplier that also returns the full double-width product,
- signed-overflow and illegal-opcode flags,
- a ZERO flag that is actually driven.

It sits between the register-file read stage and writeback. Control holds the pipeline while busy is high.

Parameters:
WIDTH, 32, operand and result width in bits (≥2).
CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived; not to be overridden).

Ports:
clk  input  1  single system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
A  input  WIDTH  operand A; captured when start is accepted.
B  input  WIDTH  operand B; captured when start is accepted.
alu_cs  input  6  opcode; captured when start is accepted.
busy  output  1  high whenever state ≠ IDLE.
done  output  1  one-cycle pulse; result and flags valid from this cycle onwards.
result  output  WIDTH  operation result, or the low half of the product for MUL.
result_hi  output  WIDTH  high half of the product for MUL; 0 for every other opcode.
ZERO  output  1  (result == 0); for MUL, the low half only.
OVF  output  1  signed overflow; ADD/SUB only, 0 otherwise.
ILLEGAL  output  1  alu_cs was not a supported opcode.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, result=0, result_hi=0, ZERO=1, OVF=0, ILLEGAL=0. All internal registers cleared.
- Reset mid-operation aborts immediately. No done is issued and the partial product is discarded.
- Opcodes:
  - 100100 AND
  - 100101 OR
  - 100000 ADD (mod 2^WIDTH)
  - 100010 SUB A−B (mod 2^WIDTH)
  - 011000 MUL (unsigned, 2·WIDTH-bit product)
  - 101010 SLT: result = {0…,1} if $signed(A)<$signed(B), else 0
  - anything else is illegal
- States: IDLE, MUL, DONE.
  - IDLE: on start=1 at edge k, latch A, B, alu_cs. MUL opcode → MUL. Any other opcode → compute and register outputs at edge k → DONE.
  - MUL: radix-2 shift-add. One multiplier bit is consumed per cycle, LSB first. The counter runs 0..WIDTH−1. At the edge where counter=WIDTH−1, result/result_hi/ZERO are registered and the state moves to DONE.
  - DONE: done=1 for exactly one cycle, then unconditional → IDLE.
- Latency, with start sampled at edge k:
  - non-MUL: done high during cycle k+1.
  - MUL: done high during cycle k+WIDTH+1.
  - Minimum issue interval: 2 cycles for non-MUL, WIDTH+2 cycles for MUL.
- start while busy (MUL or DONE) is ignored. It is neither queued nor allowed to affect the in-flight operation.
- Input changes on A/B/alu_cs after acceptance have no effect.
- result, result_hi and the flags hold their value from done until the next completion. They do not change during a subsequent operation until that operation's done.
- OVF:
  - ADD: operand sign bits equal and result sign differs.
  - SUB: operand sign bits differ and result sign ≠ sign of A.
- ILLEGAL opcode: result=0, result_hi=0, ZERO=1, OVF=0, ILLEGAL=1. Completes with non-MUL latency. ILLEGAL clears on the next legal completion.
- The MUL accumulator is WIDTH+1 bits wide so the carry is not lost; the product is exact for all operand values, including all-ones × all-ones.

Test Plan:
- WIDTH=32, A=30, B=25, alu_cs=011000, start pulse → busy for 33 cycles; done at k+33; result=750, result_hi=0, ZERO=0.
- A=0xFFFFFFFF, B=0xFFFFFFFF, MUL → result=0x00000001, result_hi=0xFFFFFFFE; then A=0x7FFFFFFF, B=1, ADD → result=0x80000000, OVF=1, done at k+1.
- A=25, B=25, SUB → result=0, ZERO=1, OVF=0; then A=0xFFFFFFFE(−2), B=3, SLT → result=1.
- Start a MUL (A=7, B=9); pulse start with alu_cs=100100 at k+5 → ignored; single done at k+33 with result=63; next op accepted only after returning to IDLE.
- Start a MUL, assert rst at k+10 → outputs reset immediately (busy=0, result=0, ZERO=1), no done; after release an ADD 3+4 returns 7 at k'+1.
- alu_cs=111111, start → done at k+1, ILLEGAL=1, result=0, ZERO=1; next OR 0xF0|0x0F → 0xFF, ILLEGAL=0.
